wb_src_select_stage: RTL and testbench
======================================

// Module: wb_src_select_stage
// PURPOSE
// - Parametrised, registered writeback-source selector for the register-file (PRF) write port.
// - Picks one of NUM_SRC DATA_W-bit sources (ALU result, memory data, PC/instruction, ...) by sel.
// - Carries the result with its destination register address through a 2-entry skid stage
//   under valid/ready handshake.
// - Flags and counts illegal selects. Sits between execute/memory and the PRF write port.
// PARAMETERS
// - DATA_W      32  width of each source and of the output
// - NUM_SRC     4   number of sources (>=2)
// - SEL_W       $clog2(NUM_SRC)  select width (derived; do not override)
// - RADDR_W     5   destination register address width
// - ERRCNT_W    8   width of the illegal-select counter
// PORTS
// - clk          in   1                  clock, all state on rising edge
// - rst_n        in   1                  asynchronous active-low reset
// - src_data     in   NUM_SRC*DATA_W     packed sources; source i = src_data[i*DATA_W +: DATA_W]
// - sel          in   SEL_W              source index
// - in_rd        in   RADDR_W            destination register address
// - in_valid     in   1                  upstream offers {sel,src_data,in_rd}
// - in_ready     out  1                  stage can accept
// - out_data     out  DATA_W             selected data to PRF
// - out_rd       out  RADDR_W            destination address to PRF
// - out_valid    out  1                  out_data/out_rd valid
// - out_ready    in   1                  PRF accepts
// - illegal_sel  out  1                  sticky: an accepted transfer had sel >= NUM_SRC
// - err_cnt      out  ERRCNT_W           saturating count of accepted illegal selects
// - clr_err      in   1                  sync clear of illegal_sel and err_cnt
// BEHAVIOUR
// - Reset (async, rst_n=0): out_valid=0, in_ready=1, out_data=0, out_rd=0, illegal_sel=0,
//   err_cnt=0; both entries empty. Reset mid-transfer discards held entries; no output until new input.
// - Transfers:
//   - in_fire  = in_valid & in_ready
//   - out_fire = out_valid & out_ready
//   - Data is sampled on in_fire only.
// - Select: sel < NUM_SRC -> source sel; sel >= NUM_SRC (non-power-of-2 NUM_SRC) -> data 0,
//   entry still transferred.
// - Latency: 1 cycle; in_fire at edge N -> out_valid high after edge N.
// - Throughput: 1 transfer/cycle when out_ready is held high.
// - Storage: main register (drives outputs) + skid register. in_ready = !skid_full (registered).
// - FSM:
//   - EMPTY:
//     - in_fire -> load main -> ONE.
//   - ONE (out_valid=1):
//     - in_fire & out_fire   -> main <= input, stay ONE.
//     - in_fire & !out_fire  -> skid <= input -> FULL.
//     - !in_fire & out_fire  -> EMPTY.
//     - otherwise hold.
//   - FULL (in_ready=0):
//     - out_fire -> main <= skid -> ONE.
//     - otherwise hold.
// - Outputs are stable while out_valid & !out_ready; ordering is strictly FIFO.
// - Errors:
//   - On in_fire with sel >= NUM_SRC: illegal_sel <= 1; err_cnt += 1, saturating at all-ones.
//   - clr_err clears both next cycle and wins over a simultaneous increment.
//   - Errors do not stall the pipe.
// - in_valid=0 cycles: sel, src_data and in_rd are don't-care; no state change from inputs.
// TESTING
// - Reset:
//   - Stimulus: assert rst_n=0 mid-FULL.
//   - Required: out_valid=0, in_ready=1, err_cnt=0 immediately; out_valid stays 0 until next in_fire.
// - Streaming:
//   - Stimulus: NUM_SRC=4, sources {0x11,0x22,0x33,0x44}, sel 0,1,2,3 on back-to-back cycles,
//     out_ready=1.
//   - Required: out_data 0x11,0x22,0x33,0x44 on consecutive cycles, each 1 cycle after its input;
//     in_ready stays 1.
// - Backpressure:
//   - Stimulus: out_ready=0, offer A (rd=3) then B (rd=7).
//   - Required: A held on outputs; B in skid; in_ready=0 and C is not accepted.
//   - Stimulus: raise out_ready.
//   - Required: A, B, C emerge in order with no loss or duplication.
// - Illegal select:
//   - Stimulus: NUM_SRC=3, sel=3 accepted.
//   - Required: out_data=0, illegal_sel=1, err_cnt=1.
//   - Stimulus: 300 illegal selects with ERRCNT_W=8.
//   - Required: err_cnt=255.
// - Clear priority:
//   - Stimulus: clr_err and an illegal in_fire in the same cycle.
//   - Required: illegal_sel=0, err_cnt=0 next cycle.
// - Random:
//   - Stimulus: random in_valid/out_ready over 10k cycles, NUM_SRC=5, DATA_W=16.
//   - Required: scoreboard shows every accepted entry delivered exactly once, in order.

Source files
------------

// File: rtl/wb_src_select_stage.sv
// Writeback-source selector with a 2-entry skid stage feeding the PRF write port.
// Picks one of NUM_SRC sources by sel, carries it with its destination register
// address under valid/ready handshake, and flags/counts illegal selects.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   src_data, sel, in_rd  packed sources, source index, destination address
//   in_valid / in_ready   upstream handshake
//   out_data, out_rd      selected data and destination address to the PRF
//   out_valid / out_ready downstream handshake
//   illegal_sel, err_cnt  sticky illegal-select flag, saturating illegal-select count
//   clr_err               synchronous clear of illegal_sel and err_cnt
module wb_src_select_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_SRC  = 4,
    parameter int unsigned SEL_W    = $clog2(NUM_SRC),
    parameter int unsigned RADDR_W  = 5,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic [RADDR_W-1:0]        in_rd,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [RADDR_W-1:0]        out_rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      illegal_sel,
    output logic [ERRCNT_W-1:0]       err_cnt,
    input  logic                      clr_err
);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 in_fire;
    logic                 out_fire;
    logic                 sel_illegal;
    logic [DATA_W-1:0]    sel_data;
    logic                 load_main_in;
    logic                 load_main_skid;
    logic                 load_skid;
    logic [DATA_W-1:0]    skid_data;
    logic [RADDR_W-1:0]   skid_rd;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Compare in 32 bits so a power-of-two NUM_SRC never wraps to zero.
    assign sel_illegal = (32'(sel) >= NUM_SRC);

    // Source mux; an out-of-range select leaves the default of zero.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (32'(sel) == i) begin
                sel_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_ONE;
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = ST_FULL;
                end else if (!in_fire && out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL:  if (out_fire) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Datapath load controls.
    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            ST_EMPTY: load_main_in = in_fire;
            ST_ONE: begin
                load_main_in = in_fire & out_fire;
                load_skid    = in_fire & ~out_fire;
            end
            ST_FULL:  load_main_skid = out_fire;
            default: ;
        endcase
    end

    // Handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            out_valid <= (state_d != ST_EMPTY);
            in_ready  <= (state_d != ST_FULL);
        end
    end

    // Main register drives the outputs; skid holds the second entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_rd    <= '0;
            skid_data <= '0;
            skid_rd   <= '0;
        end else begin
            if (load_main_in) begin
                out_data <= sel_data;
                out_rd   <= in_rd;
            end else if (load_main_skid) begin
                out_data <= skid_data;
                out_rd   <= skid_rd;
            end
            if (load_skid) begin
                skid_data <= sel_data;
                skid_rd   <= in_rd;
            end
        end
    end

    // Illegal-select tracking; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_sel <= 1'b0;
            err_cnt     <= '0;
        end else if (clr_err) begin
            illegal_sel <= 1'b0;
            err_cnt     <= '0;
        end else if (in_fire && sel_illegal) begin
            illegal_sel <= 1'b1;
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + ERRCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_src_select_stage.sv
module tb_wb_src_select_stage;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Main DUT: NUM_SRC=5, DATA_W=16 (sel 5..7 illegal).
    logic [79:0] src_data;
    logic [2:0]  sel;
    logic [4:0]  in_rd;
    logic        in_valid, in_ready;
    logic [15:0] out_data;
    logic [4:0]  out_rd;
    logic        out_valid, out_ready;
    logic        illegal_sel;
    logic [7:0]  err_cnt;
    logic        clr_err;

    wb_src_select_stage #(
        .DATA_W(16), .NUM_SRC(5), .RADDR_W(5), .ERRCNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .src_data(src_data), .sel(sel), .in_rd(in_rd),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_rd(out_rd),
        .out_valid(out_valid), .out_ready(out_ready), .illegal_sel(illegal_sel),
        .err_cnt(err_cnt), .clr_err(clr_err)
    );

    // Second DUT: NUM_SRC=4, DATA_W=32 for the streaming case.
    logic [127:0] src4;
    logic [1:0]   sel4;
    logic [4:0]   in_rd4, out_rd4;
    logic         in_valid4, in_ready4, out_valid4, out_ready4, illegal4;
    logic [31:0]  out_data4;
    logic [7:0]   err_cnt4;

    wb_src_select_stage #(
        .DATA_W(32), .NUM_SRC(4), .RADDR_W(5), .ERRCNT_W(8)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .src_data(src4), .sel(sel4), .in_rd(in_rd4),
        .in_valid(in_valid4), .in_ready(in_ready4), .out_data(out_data4), .out_rd(out_rd4),
        .out_valid(out_valid4), .out_ready(out_ready4), .illegal_sel(illegal4),
        .err_cnt(err_cnt4), .clr_err(1'b0)
    );

    // Reference model: a 2-deep FIFO whose head is what the outputs show.
    typedef struct {
        logic [15:0] d;
        logic [4:0]  rd;
    } ent_t;
    ent_t q[$];
    logic m_ill;
    int   m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check_eq("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            check_eq("out_data", 32'(out_data), 32'(q[0].d));
            check_eq("out_rd", 32'(out_rd), 32'(q[0].rd));
        end
        check_eq("illegal_sel", 32'(illegal_sel), 32'(m_ill));
        check_eq("err_cnt", 32'(err_cnt), 32'(m_cnt));
    endtask

    // Drive one cycle at the negedge, advance the model, check after the next edge.
    task automatic cycle(input logic v, input logic [2:0] s, input logic [4:0] rd,
                         input logic [79:0] src, input logic ordy, input logic clr);
        ent_t e;
        logic fin, fout;
        in_valid  = v;
        sel       = s;
        in_rd     = rd;
        src_data  = src;
        out_ready = ordy;
        clr_err   = clr;
        fin  = v && (q.size() < 2);
        fout = (q.size() > 0) && ordy;
        e.d  = (s < 3'd5) ? 16'(src >> (32'(s) * 16)) : 16'h0;
        e.rd = rd;
        if (fout) void'(q.pop_front());
        if (fin) q.push_back(e);
        if (clr) begin
            m_ill = 1'b0;
            m_cnt = 0;
        end else if (fin && s >= 3'd5) begin
            m_ill = 1'b1;
            m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        end
        @(posedge clk);
        @(negedge clk);
        check_state();
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 3'($urandom), 5'($urandom), 80'({$urandom, $urandom, $urandom}), ordy, 1'b0);
    endtask

    logic [79:0] src_fix;
    logic [31:0] exp4 [4];

    initial begin
        src_fix = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        exp4 = '{32'h11, 32'h22, 32'h33, 32'h44};
        m_ill = 1'b0;
        m_cnt = 0;
        rst_n = 1'b0;
        in_valid = 1'b0; sel = '0; in_rd = '0; src_data = '0; out_ready = 1'b0; clr_err = 1'b0;
        in_valid4 = 1'b0; sel4 = '0; in_rd4 = '0; out_ready4 = 1'b1;
        src4 = {32'h44, 32'h33, 32'h22, 32'h11};
        repeat (2) @(negedge clk);

        // Reset values.
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_in_ready", 32'(in_ready), 32'h1);
        check_eq("rst_out_data", 32'(out_data), 32'h0);
        check_eq("rst_out_rd", 32'(out_rd), 32'h0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'h0);
        check_eq("rst_illegal", 32'(illegal_sel), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Streaming on the 4-source instance: one result per cycle, 1-cycle latency.
        for (int i = 0; i < 4; i++) begin
            in_valid4 = 1'b1;
            sel4      = 2'(i);
            in_rd4    = 5'(i + 1);
            @(posedge clk);
            @(negedge clk);
            check_eq("s4_out_valid", 32'(out_valid4), 32'h1);
            check_eq("s4_out_data", out_data4, exp4[i]);
            check_eq("s4_out_rd", 32'(out_rd4), 32'(i + 1));
            check_eq("s4_in_ready", 32'(in_ready4), 32'h1);
            check_eq("s4_illegal", 32'(illegal4), 32'h0);
        end
        in_valid4 = 1'b0;

        // Streaming on the main instance, each legal source.
        for (int i = 0; i < 5; i++) cycle(1'b1, 3'(i), 5'(i), src_fix, 1'b1, 1'b0);
        idle(1'b1);

        // Backpressure: A held, B in skid, C refused until space frees.
        cycle(1'b1, 3'd0, 5'd3, src_fix, 1'b0, 1'b0);
        cycle(1'b1, 3'd1, 5'd7, src_fix, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 5'd9, src_fix, 1'b0, 1'b0);
        check_eq("bp_in_ready_low", 32'(in_ready), 32'h0);
        check_eq("bp_hold_rd", 32'(out_rd), 32'd3);
        cycle(1'b1, 3'd2, 5'd9, src_fix, 1'b1, 1'b0);
        check_eq("bp_b_rd", 32'(out_rd), 32'd7);
        cycle(1'b1, 3'd2, 5'd9, src_fix, 1'b1, 1'b0);
        check_eq("bp_c_rd", 32'(out_rd), 32'd9);
        idle(1'b1);
        idle(1'b1);

        // Illegal select: zero data, flag and count.
        cycle(1'b1, 3'd5, 5'd4, src_fix, 1'b1, 1'b0);
        check_eq("ill_data", 32'(out_data), 32'h0);
        check_eq("ill_flag", 32'(illegal_sel), 32'h1);
        check_eq("ill_cnt", 32'(err_cnt), 32'h1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 3'(5 + (i % 3)), 5'(i), src_fix, 1'b1, 1'b0);
        check_eq("ill_sat", 32'(err_cnt), 32'd255);

        // Clear wins over a simultaneous illegal transfer.
        cycle(1'b1, 3'd6, 5'd1, src_fix, 1'b1, 1'b1);
        check_eq("clr_flag", 32'(illegal_sel), 32'h0);
        check_eq("clr_cnt", 32'(err_cnt), 32'h0);

        // Reset in the middle of a full stage.
        cycle(1'b1, 3'd7, 5'd2, src_fix, 1'b0, 1'b0);
        cycle(1'b1, 3'd3, 5'd5, src_fix, 1'b0, 1'b0);
        check_eq("pre_rst_full", 32'(in_ready), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'h1);
        check_eq("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
        q.delete();
        m_ill = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        idle(1'b0);
        idle(1'b1);
        cycle(1'b1, 3'd4, 5'd30, src_fix, 1'b0, 1'b0);
        idle(1'b1);

        // Random traffic against the FIFO model.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom), 3'($urandom_range(0, 7)), 5'($urandom),
                  80'({$urandom, $urandom, $urandom}), 1'($urandom),
                  ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        check_eq("drained", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
